// File: rtl/ibex_noc_pkg.sv
// Shared types, default parameters and payload masking for the Ibex NoC message port.
package ibex_noc_pkg;

   localparam int unsigned MsgWordsDef = 4;
   localparam int unsigned TxDepthDef  = 4;
   localparam int unsigned RxDepthDef  = 4;
   localparam int unsigned CoreIdWDef  = 5;
   localparam int unsigned RegAddrWDef = 5;
   localparam int unsigned LenWDef     = 2;

   localparam int unsigned MsgWordsMax = 8;
   localparam int unsigned LenWMax     = 3;
   localparam int unsigned MaskW       = 32 * MsgWordsMax;

   // Message view for the default configuration.
   typedef struct packed {
      logic [LenWDef-1:0]        len;
      logic [CoreIdWDef-1:0]     core;
      logic [RegAddrWDef-1:0]    addr;
      logic [32*MsgWordsDef-1:0] data;
   } noc_msg_t;

   // Zero every payload word beyond the message length (len = words minus one).
   function automatic logic [MaskW-1:0] noc_mask_payload(input logic [LenWMax-1:0] len,
                                                         input logic [MaskW-1:0]   data);
      logic [MaskW-1:0] res;
      res = data;
      for (int unsigned w = 0; w < MsgWordsMax; w++) begin
         if (w > 32'(len)) res[32*w +: 32] = '0;
      end
      return res;
   endfunction

endpackage

// File: rtl/ibex_noc_msg_fifo.sv
// Pointer-based message FIFO with wrap-bit full/empty and a registered occupancy count.
module ibex_noc_msg_fifo
   import ibex_noc_pkg::*;
#(
   parameter int unsigned Depth = 4,
   parameter int unsigned Width = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic [Width-1:0]       wdata_i,
   output logic [Width-1:0]       rdata_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(Depth):0] count_o
);

   localparam int unsigned IdxW = $clog2(Depth);

   logic [IdxW:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, cnt_q, cnt_d;
   logic [Width-1:0] mem_q [Depth];
   logic             push_ok, pop_ok;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[IdxW-1:0] == rd_ptr_q[IdxW-1:0]) &&
                    (wr_ptr_q[IdxW] != rd_ptr_q[IdxW]);

   // A push into a full queue lands only when the head leaves in the same cycle.
   assign pop_ok  = pop_i && !empty_o;
   assign push_ok = push_i && (!full_o || pop_ok);

   assign wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
   assign rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
   assign cnt_d    = cnt_q + (IdxW+1)'(push_ok) - (IdxW+1)'(pop_ok);

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q[IdxW-1:0]] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_ptr_q[IdxW-1:0]];
   assign count_o = cnt_q;

endmodule

// File: rtl/ibex_noc_msg_port.sv
// Buffered Ibex <-> NoC message port: TX queue with req/gnt, RX queue with drop/overflow.
// Define IBEX_NOC_MSG_STATS_EN to add sent/received/dropped message counters.
module ibex_noc_msg_port
   import ibex_noc_pkg::*;
#(
   parameter int unsigned MsgWords = MsgWordsDef,
   parameter int unsigned TxDepth  = TxDepthDef,
   parameter int unsigned RxDepth  = RxDepthDef,
   parameter int unsigned CoreIdW  = CoreIdWDef,
   parameter int unsigned RegAddrW = RegAddrWDef,
   localparam int unsigned LenW    = (MsgWords > 1) ? $clog2(MsgWords) : 1,
   localparam int unsigned DataW   = 32 * MsgWords
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                tx_valid_i,
   output logic                tx_ready_o,
   input  logic [LenW-1:0]     tx_len_i,
   input  logic [CoreIdW-1:0]  tx_core_i,
   input  logic [RegAddrW-1:0] tx_addr_i,
   input  logic [DataW-1:0]    tx_data_i,
   output logic                noc_req_o,
   input  logic                noc_gnt_i,
   output logic [LenW-1:0]     noc_len_o,
   output logic [CoreIdW-1:0]  noc_core_o,
   output logic [RegAddrW-1:0] noc_addr_o,
   output logic [DataW-1:0]    noc_data_o,
   input  logic                noc_valid_i,
   input  logic [LenW-1:0]     noc_len_i,
   input  logic [RegAddrW-1:0] noc_addr_i,
   input  logic [DataW-1:0]    noc_data_i,
   output logic                rx_valid_o,
   input  logic                rx_ready_i,
   output logic [LenW-1:0]     rx_len_o,
   output logic [RegAddrW-1:0] rx_addr_o,
   output logic [DataW-1:0]    rx_data_o,
   output logic                rx_drop_o,
   output logic                rx_overflow_o,
   input  logic                rx_overflow_clr_i
`ifdef IBEX_NOC_MSG_STATS_EN
   ,
   output logic [31:0]         tx_sent_cnt_o,
   output logic [31:0]         rx_recv_cnt_o,
   output logic [15:0]         rx_drop_cnt_o
`endif
);

   localparam int unsigned TxW = LenW + CoreIdW + RegAddrW + DataW;
   localparam int unsigned RxW = LenW + RegAddrW + DataW;

   logic                    tx_full, tx_empty, tx_push, tx_pop;
   logic [TxW-1:0]          tx_rdata;
   logic [$clog2(TxDepth):0] tx_cnt;
   logic [LenW-1:0]         tx_len;

   logic                    rx_full, rx_empty, rx_pop, rx_wr, rx_drop_now;
   logic [RxW-1:0]          rx_rdata;
   logic [$clog2(RxDepth):0] rx_cnt;
   logic [LenW-1:0]         rx_len;

   logic                    rx_drop_q, rx_drop_d, rx_ovf_q, rx_ovf_d;
   logic                    unused_cnt;

   // TX: no bypass, and a full queue refuses even while the head is granted.
   assign tx_ready_o = !tx_full;
   assign noc_req_o  = !tx_empty;
   assign tx_push    = tx_valid_i && !tx_full;
   assign tx_pop     = noc_req_o && noc_gnt_i;

   ibex_noc_msg_fifo #(.Depth(TxDepth), .Width(TxW)) u_tx_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (tx_push),
      .pop_i   (tx_pop),
      .wdata_i ({tx_len_i, tx_core_i, tx_addr_i, tx_data_i}),
      .rdata_o (tx_rdata),
      .full_o  (tx_full),
      .empty_o (tx_empty),
      .count_o (tx_cnt)
   );

   assign tx_len     = tx_rdata[TxW-1 -: LenW];
   assign noc_len_o  = tx_empty ? '0 : tx_len;
   assign noc_core_o = tx_empty ? '0 : tx_rdata[DataW+RegAddrW +: CoreIdW];
   assign noc_addr_o = tx_empty ? '0 : tx_rdata[DataW +: RegAddrW];
   assign noc_data_o = tx_empty ? '0 :
      DataW'(noc_mask_payload(LenWMax'(tx_len), MaskW'(tx_rdata[DataW-1:0])));

   // RX: a full queue still takes the strobe if the core frees the head this cycle.
   assign rx_valid_o  = !rx_empty;
   assign rx_pop      = rx_valid_o && rx_ready_i;
   assign rx_wr       = noc_valid_i && (!rx_full || rx_pop);
   assign rx_drop_now = noc_valid_i && !rx_wr;

   ibex_noc_msg_fifo #(.Depth(RxDepth), .Width(RxW)) u_rx_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (rx_wr),
      .pop_i   (rx_pop),
      .wdata_i ({noc_len_i, noc_addr_i, noc_data_i}),
      .rdata_o (rx_rdata),
      .full_o  (rx_full),
      .empty_o (rx_empty),
      .count_o (rx_cnt)
   );

   assign rx_len    = rx_rdata[RxW-1 -: LenW];
   assign rx_len_o  = rx_empty ? '0 : rx_len;
   assign rx_addr_o = rx_empty ? '0 : rx_rdata[DataW +: RegAddrW];
   assign rx_data_o = rx_empty ? '0 :
      DataW'(noc_mask_payload(LenWMax'(rx_len), MaskW'(rx_rdata[DataW-1:0])));

   // A new drop takes priority over a clear in the same cycle.
   assign rx_drop_d = rx_drop_now;
   assign rx_ovf_d  = rx_drop_now || (rx_ovf_q && !rx_overflow_clr_i);

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rx_drop_q <= 1'b0;
         rx_ovf_q  <= 1'b0;
      end else begin
         rx_drop_q <= rx_drop_d;
         rx_ovf_q  <= rx_ovf_d;
      end
   end

   assign rx_drop_o     = rx_drop_q;
   assign rx_overflow_o = rx_ovf_q;
   assign unused_cnt    = ^{tx_cnt, rx_cnt};

`ifdef IBEX_NOC_MSG_STATS_EN
   logic [31:0] tx_sent_q, rx_recv_q;
   logic [15:0] rx_drop_cnt_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         tx_sent_q     <= '0;
         rx_recv_q     <= '0;
         rx_drop_cnt_q <= '0;
      end else begin
         if (tx_pop) tx_sent_q <= tx_sent_q + 32'd1;
         if (rx_wr)  rx_recv_q <= rx_recv_q + 32'd1;
         if (rx_drop_now && (rx_drop_cnt_q != 16'hFFFF)) rx_drop_cnt_q <= rx_drop_cnt_q + 16'd1;
      end
   end

   assign tx_sent_cnt_o = tx_sent_q;
   assign rx_recv_cnt_o = rx_recv_q;
   assign rx_drop_cnt_o = rx_drop_cnt_q;
`endif

endmodule

// File: tb/tb_ibex_noc_msg_port.sv
// Directed + randomized bench for ibex_noc_msg_port against a queue-based reference model.
module tb_ibex_noc_msg_port;
   import ibex_noc_pkg::*;

   logic         clk_i = 1'b0;
   logic         rst_ni = 1'b0;
   logic         tx_valid_i = 1'b0, tx_ready_o;
   logic [1:0]   tx_len_i = '0;
   logic [4:0]   tx_core_i = '0, tx_addr_i = '0;
   logic [127:0] tx_data_i = '0;
   logic         noc_req_o, noc_gnt_i = 1'b0;
   logic [1:0]   noc_len_o;
   logic [4:0]   noc_core_o, noc_addr_o;
   logic [127:0] noc_data_o;
   logic         noc_valid_i = 1'b0;
   logic [1:0]   noc_len_i = '0;
   logic [4:0]   noc_addr_i = '0;
   logic [127:0] noc_data_i = '0;
   logic         rx_valid_o, rx_ready_i = 1'b0;
   logic [1:0]   rx_len_o;
   logic [4:0]   rx_addr_o;
   logic [127:0] rx_data_o;
   logic         rx_drop_o, rx_overflow_o, rx_overflow_clr_i = 1'b0;
`ifdef IBEX_NOC_MSG_STATS_EN
   logic [31:0]  tx_sent_cnt_o, rx_recv_cnt_o;
   logic [15:0]  rx_drop_cnt_o;
`endif

   int tests = 0;
   int fails = 0;

   noc_msg_t txq[$];
   noc_msg_t rxq[$];
   logic     drop_e = 1'b0, ovf_e = 1'b0;
   int       sent_e = 0, recv_e = 0, drops_e = 0;

   always #5 clk_i = ~clk_i;

   ibex_noc_msg_port dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o), .tx_len_i(tx_len_i),
      .tx_core_i(tx_core_i), .tx_addr_i(tx_addr_i), .tx_data_i(tx_data_i),
      .noc_req_o(noc_req_o), .noc_gnt_i(noc_gnt_i), .noc_len_o(noc_len_o),
      .noc_core_o(noc_core_o), .noc_addr_o(noc_addr_o), .noc_data_o(noc_data_o),
      .noc_valid_i(noc_valid_i), .noc_len_i(noc_len_i), .noc_addr_i(noc_addr_i),
      .noc_data_i(noc_data_i), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
      .rx_len_o(rx_len_o), .rx_addr_o(rx_addr_o), .rx_data_o(rx_data_o),
      .rx_drop_o(rx_drop_o), .rx_overflow_o(rx_overflow_o),
      .rx_overflow_clr_i(rx_overflow_clr_i)
`ifdef IBEX_NOC_MSG_STATS_EN
      , .tx_sent_cnt_o(tx_sent_cnt_o), .rx_recv_cnt_o(rx_recv_cnt_o),
      .rx_drop_cnt_o(rx_drop_cnt_o)
`endif
   );

   function automatic noc_msg_t rand_msg();
      noc_msg_t m;
      m.len  = 2'($urandom_range(0, 3));
      m.core = 5'($urandom);
      m.addr = 5'($urandom);
      m.data = {$urandom, $urandom, $urandom, $urandom};
      return m;
   endfunction

   // Words past len read as zero.
   function automatic logic [127:0] masked(noc_msg_t m);
      logic [127:0] d;
      d = m.data;
      for (int w = 0; w < 4; w++) if (w > int'(m.len)) d[32*w +: 32] = '0;
      return d;
   endfunction

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_tx(input noc_msg_t m);
      tx_len_i = m.len; tx_core_i = m.core; tx_addr_i = m.addr; tx_data_i = m.data;
   endtask

   task automatic set_rx(input noc_msg_t m);
      noc_len_i = m.len; noc_addr_i = m.addr; noc_data_i = m.data;
   endtask

   // Advance the model with the inputs present at this edge, then clock the DUT.
   task automatic step();
      bit       tpop, tpush, rpop, rwr;
      noc_msg_t m;
      if (!rst_ni) begin
         txq.delete(); rxq.delete();
         drop_e = 1'b0; ovf_e = 1'b0;
         sent_e = 0; recv_e = 0; drops_e = 0;
      end else begin
         tpop   = (txq.size() > 0) && noc_gnt_i;
         tpush  = tx_valid_i && (txq.size() < 4);
         rpop   = (rxq.size() > 0) && rx_ready_i;
         rwr    = noc_valid_i && ((rxq.size() < 4) || rpop);
         drop_e = noc_valid_i && !rwr;
         ovf_e  = drop_e || (ovf_e && !rx_overflow_clr_i);
         if (tpop) begin void'(txq.pop_front()); sent_e++; end
         if (tpush) begin
            m.len = tx_len_i; m.core = tx_core_i; m.addr = tx_addr_i; m.data = tx_data_i;
            txq.push_back(m);
         end
         if (rpop) void'(rxq.pop_front());
         if (rwr) begin
            m.len = noc_len_i; m.core = '0; m.addr = noc_addr_i; m.data = noc_data_i;
            rxq.push_back(m);
            recv_e++;
         end
         if (drop_e) drops_e++;
      end
      @(posedge clk_i);
      #1;
   endtask

   task automatic check_all(input string ph);
      noc_msg_t h;
      chk({ph, ":tx_ready"}, 256'(tx_ready_o), 256'(txq.size() < 4));
      chk({ph, ":noc_req"}, 256'(noc_req_o), 256'(txq.size() != 0));
      h = '0;
      if (txq.size() != 0) h = txq[0];
      chk({ph, ":noc_len"}, 256'(noc_len_o), 256'(h.len));
      chk({ph, ":noc_core"}, 256'(noc_core_o), 256'(h.core));
      chk({ph, ":noc_addr"}, 256'(noc_addr_o), 256'(h.addr));
      chk({ph, ":noc_data"}, 256'(noc_data_o), 256'(masked(h)));
      h = '0;
      if (rxq.size() != 0) h = rxq[0];
      chk({ph, ":rx_valid"}, 256'(rx_valid_o), 256'(rxq.size() != 0));
      chk({ph, ":rx_len"}, 256'(rx_len_o), 256'(h.len));
      chk({ph, ":rx_addr"}, 256'(rx_addr_o), 256'(h.addr));
      chk({ph, ":rx_data"}, 256'(rx_data_o), 256'(masked(h)));
      chk({ph, ":rx_drop"}, 256'(rx_drop_o), 256'(drop_e));
      chk({ph, ":rx_ovf"}, 256'(rx_overflow_o), 256'(ovf_e));
   endtask

   initial begin
      noc_msg_t m;

      // Reset state
      rst_ni = 1'b0;
      step();
      rst_ni = 1'b1;
      check_all("reset");
      chk("reset:tx_ready_const", 256'(tx_ready_o), 256'(1));
      chk("reset:noc_req_const", 256'(noc_req_o), 256'(0));

      // Single message held under gnt=0, words 2..3 masked
      m.len = 2'd1; m.core = 5'd3; m.addr = 5'd7;
      m.data = {32'hCAFEF00D, 32'h12345678, 32'h00000001, 32'hDEADBEEF};
      set_tx(m); tx_valid_i = 1'b1;
      chk("t1:no_bypass", 256'(noc_req_o), 256'(0));
      step();
      tx_valid_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check_all("t1_hold");
         chk("t1:word0", 256'(noc_data_o[31:0]), 256'(32'hDEADBEEF));
         chk("t1:word1", 256'(noc_data_o[63:32]), 256'(32'h1));
         chk("t1:word23", 256'(noc_data_o[127:64]), 256'(0));
         step();
      end
      noc_gnt_i = 1'b1;
      step();
      noc_gnt_i = 1'b0;
      check_all("t1_gnt");
      chk("t1:req_low", 256'(noc_req_o), 256'(0));

      // Fill TX, 5th refused, drain 1/cycle
      for (int i = 0; i < 5; i++) begin
         set_tx(rand_msg()); tx_valid_i = 1'b1;
         step();
         check_all("t2_fill");
      end
      chk("t2:full", 256'(tx_ready_o), 256'(0));
      tx_valid_i = 1'b1; noc_gnt_i = 1'b1;
      chk("t2:full_gnt_no_pass", 256'(tx_ready_o), 256'(0));
      step();
      tx_valid_i = 1'b0;
      check_all("t2_drain");
      for (int i = 0; i < 4; i++) begin
         step();
         check_all("t2_drain");
      end
      noc_gnt_i = 1'b0;
      chk("t2:ready_back", 256'(tx_ready_o), 256'(1));

      // Fill RX, drop the 5th, accept the 6th with a simultaneous pop
      rx_ready_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         set_rx(rand_msg()); noc_valid_i = 1'b1;
         step();
         noc_valid_i = 1'b0;
         check_all("t3_fill");
      end
      chk("t3:drop", 256'(rx_drop_o), 256'(1));
      step();
      check_all("t3_drop_gone");
      chk("t3:drop_one_cycle", 256'(rx_drop_o), 256'(0));
      set_rx(rand_msg()); noc_valid_i = 1'b1; rx_ready_i = 1'b1;
      step();
      noc_valid_i = 1'b0; rx_ready_i = 1'b0;
      check_all("t3_sixth");

      // Clear coinciding with a drop keeps the flag; clear alone drops it
      set_rx(rand_msg()); noc_valid_i = 1'b1; rx_overflow_clr_i = 1'b1;
      step();
      noc_valid_i = 1'b0;
      check_all("t4_clr_drop");
      chk("t4:ovf_kept", 256'(rx_overflow_o), 256'(1));
      step();
      rx_overflow_clr_i = 1'b0;
      check_all("t4_clr");
      chk("t4:ovf_cleared", 256'(rx_overflow_o), 256'(0));
      rx_ready_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         check_all("t4_rx_drain");
      end
      rx_ready_i = 1'b0;

      // Reset with traffic queued
      for (int i = 0; i < 3; i++) begin
         set_tx(rand_msg()); tx_valid_i = 1'b1;
         set_rx(rand_msg()); noc_valid_i = (i < 2);
         step();
      end
      tx_valid_i = 1'b0; noc_valid_i = 1'b0;
      check_all("t5_queued");
      rst_ni = 1'b0;
      step();
      rst_ni = 1'b1;
      check_all("t5_after_rst");
      chk("t5:req", 256'(noc_req_o), 256'(0));
      chk("t5:rx_valid", 256'(rx_valid_o), 256'(0));
      for (int i = 0; i < 3; i++) begin
         noc_gnt_i = 1'b1; rx_ready_i = 1'b1;
         step();
         check_all("t5_gnt");
      end
      noc_gnt_i = 1'b0; rx_ready_i = 1'b0;

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         set_tx(rand_msg());
         set_rx(rand_msg());
         tx_valid_i        = ($urandom_range(0, 99) < 55);
         noc_gnt_i         = ($urandom_range(0, 99) < 45);
         noc_valid_i       = ($urandom_range(0, 99) < 50);
         rx_ready_i        = ($urandom_range(0, 99) < 40);
         rx_overflow_clr_i = ($urandom_range(0, 99) < 10);
         rst_ni            = ($urandom_range(0, 199) != 0);
         step();
         rst_ni = 1'b1;
         check_all("rand");
      end

`ifdef IBEX_NOC_MSG_STATS_EN
      chk("stats:sent", 256'(tx_sent_cnt_o), 256'(32'(sent_e)));
      chk("stats:recv", 256'(rx_recv_cnt_o), 256'(32'(recv_e)));
      chk("stats:drop", 256'(rx_drop_cnt_o), 256'(16'(drops_e)));
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
